div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
// Sequencer for DIV/DIVU in the 54-instruction CPU. It accepts one divide op from the EX stage
// and runs an internal restoring shift-subtract datapath, one quotient bit per cycle.
// It holds the pipeline stalled while it runs, applies the signed fix-ups, and writes the
// results to HI (remainder) and LO (quotient).
// PARAMETERS
// WIDTH  32  operand/result width; iteration count = WIDTH
// CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// clock     in   1      rising-edge clock; the only clock
// reset     in   1      synchronous, active-high reset
// start     in   1      request a divide; sampled only in IDLE
// is_signed in   1      1=DIV (two's complement), 0=DIVU; captured with start
// cancel    in   1      pipeline flush; aborts the op in progress
// dividend  in   WIDTH  captured with start
// divisor   in   WIDTH  captured with start
// busy      out  1      stall request to the pipeline; high in every state except IDLE
// done      out  1      one-cycle pulse; q/r are valid
// hilo_we   out  1      HI<=r, LO<=q write strobe; same cycle as done
// q         out  WIDTH  quotient, registered; holds its value until the next done
// r         out  WIDTH  remainder, registered; holds its value until the next done
// div_zero  out  1      divisor==0 flag for the last completed op; registered with q/r
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, hilo_we, div_zero = 0; q, r, counter, work regs = 0.
//   Reset has priority over everything, including in the middle of an op.
// - States:
//   IDLE -(start)-> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
// - IDLE: on start, capture operands, is_signed and the sign bits.
//   start while busy is ignored; the request is not queued.
// - PREP: if is_signed, take the magnitude of each negative operand (~x+1).
//   The magnitude of 0x80000000 stays 0x80000000 and is treated as unsigned.
//   Load rem={WIDTH{0}}, quo=|dividend|, counter=0.
// - ITER, each cycle: {rem,quo} <<= 1.
//   If rem >= |divisor|, then rem -= |divisor| and quo[0] = 1.
//   Compare and subtract are WIDTH+1 bits wide, so there is no overflow.
//   Leave ITER when counter == WIDTH-1.
// - FIX (signed only):
//   negate quo if the sign bits differ; negate rem if the dividend was negative.
//   This gives truncating division, and the remainder takes the dividend's sign.
//   0x80000000 / -1 gives q=0x80000000, r=0, with no trap.
// - DONE: q<=quo, r<=rem, and div_zero<=(divisor==0) are registered on entry to DONE.
//   done=hilo_we=1 for that single cycle and busy stays 1. The next cycle is IDLE with busy=0.
// - Latency: start sampled at edge 0 -> done high in cycle WIDTH+3 (35 for WIDTH=32).
//   The earliest next start is sampled one cycle after done.
// - cancel in PREP, ITER or FIX: go to IDLE at the next edge. No done, no hilo_we; q, r, div_zero unchanged.
// - cancel in DONE is ignored: the write is already committed. cancel in IDLE is ignored.
// - start and cancel together in IDLE: cancel wins and the op is not accepted.
// - Divisor 0, no trap: q = all ones (unsigned), r = dividend.
//   Signed: the signs are fixed up from this raw result.
// CONFIGURATION
// - DIV_ZERO_FAST_EN defined: a zero divisor, detected in PREP, jumps PREP->DONE directly.
//   Result: q=all ones, r=dividend, div_zero=1. done in cycle 2, ignoring the sign fix-up.
// - DIV_ZERO_FAST_EN undefined: a zero divisor runs the full ITER/FIX path; done in cycle WIDTH+3.
//   Values: DIVU gives q=0xFFFFFFFF, r=dividend. DIV gives the sign-fixed result of the same raw values.
//   div_zero=1 in both cases.
// TESTING
// - DIVU 7/2, start at cycle 0 -> busy cycles 1..35; done=hilo_we=1 only at cycle 35; q=3, r=1.
// - DIV 0xFFFFFFF9/2 (-7/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//   DIV 7/0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
// - DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, div_zero=0.
//   DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
// - DIVU 5/0 -> with _EN: done at cycle 2, q=0xFFFFFFFF, r=5, div_zero=1.
//   Without _EN: done at cycle 35, same values.
// - cancel at cycle 10 -> busy=0 at 11; no done/hilo_we; q, r keep their old values.
//   A new start at 12 -> correct result at cycle 47.
// - start pulses at cycles 5 and 20 during an op -> ignored.
//   reset at cycle 15 -> cycle 16: IDLE, all outputs 0.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - DIV/DIVU sequencer with restoring shift-subtract datapath; optional DIV_ZERO_FAST_EN
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             div_zero_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // One restoring step plus the signed fix-up values, shared by ITER and FIX
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    quo_sh  = {quo_q[WIDTH-2:0], 1'b0};
    rem_ge  = (rem_sh >= {1'b0, dvs_q});
    // Only used when rem_sh >= divisor, so the difference always fits WIDTH bits
    rem_sub = rem_sh[WIDTH-1:0] - dvs_q;
    q_fix   = (dvd_neg_q != dvs_neg_q) ? (~quo_q + ONE) : quo_q;
    r_fix   = dvd_neg_q ? (~rem_q + ONE) : rem_q;
  end

  // Next-state and datapath update; everything holds unless the state says otherwise
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    unique case (state_q)
      S_IDLE: begin
        // Sign flags already fold in is_signed, so DIVU never fixes up
        if (start_i && !cancel_i) begin
          dvd_d     = dividend_i;
          dvs_d     = divisor_i;
          dvd_neg_d = is_signed_i & dividend_i[WIDTH-1];
          dvs_neg_d = is_signed_i & divisor_i[WIDTH-1];
          state_d   = S_PREP;
        end
      end
      S_PREP: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          // Magnitude of the most negative value wraps to itself and is used as unsigned
          rem_d   = '0;
          quo_d   = dvd_neg_q ? (~dvd_q + ONE) : dvd_q;
          dvs_d   = dvs_neg_q ? (~dvs_q + ONE) : dvs_q;
          cnt_d   = '0;
          state_d = S_ITER;
`ifdef DIV_ZERO_FAST_EN
          if (dvs_q == '0) begin
            q_d     = '1;
            r_d     = dvd_q;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_ITER: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          if (rem_ge) begin
            rem_d = rem_sub;
            quo_d = quo_sh | ONE;
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = quo_sh;
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          q_d     = q_fix;
          r_d     = r_fix;
          dz_d    = (dvs_q == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Results are already committed; cancel has nothing left to abort
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign hilo_we_o  = (state_q == S_DONE);
  assign q_o        = q_q;
  assign r_o        = r_q;
  assign div_zero_o = dz_q;

endmodule
